// File: rtl/sar_code_capture.sv
`default_nettype none
// ============================================================================
// Module   : sar_code_capture
// Brief    : Frames SAR sequencer phases into 6-bit codes and queues them in a
//            2-entry valid/ready buffer with sticky flags and a push counter.
//            Optional SAR_CODE_AVG4_EN: push the truncating mean of 4 frames.
// Revision : 1.0 - initial release
// ============================================================================
module sar_code_capture #(
    parameter bit VCOMP_INV = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       OUTEN,
    input  logic             SAR_RESET,
    input  logic             VCOMP,
    input  logic             CLR_FLAGS,
    output logic [5:0]       DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic             SEQ_ERR,
    output logic             OVF,
    output logic [CNT_W-1:0] FRAME_CNT
);

    localparam logic [1:0]       c_ST_IDLE  = 2'd0;
    localparam logic [1:0]       c_ST_ARMED = 2'd1;
    localparam logic [1:0]       c_ST_CONV  = 2'd2;
    localparam logic [4:0]       c_OUTEN_B5 = 5'b10000;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_k;
    logic [2:0]       w_k_nxt;
    logic [5:0]       r_code;
    logic             w_bit;
    logic [4:0]       w_exp_outen;
    logic             w_conv_ok;
    logic             w_capture;
    logic [2:0]       w_cap_idx;
    logic             w_frame_done;
    logic             w_err_evt;
    logic [5:0]       w_code_full;
    logic             w_push;
    logic [5:0]       w_push_data;
    logic [5:0]       r_head;
    logic [5:0]       r_tail;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_full;
    logic             w_push_ok;
    logic             w_drop;
    logic             r_seq_err;
    logic             r_ovf;
    logic [CNT_W-1:0] r_frame_cnt;

    assign w_bit       = VCOMP ^ VCOMP_INV;
    assign w_code_full = {r_code[5:1], w_bit};

    always_comb begin
        w_exp_outen = 5'b00000;
        if (r_k != 3'd0) begin
            w_exp_outen = 5'b00001 << (r_k - 3'd1);
        end
    end

    assign w_conv_ok = !SAR_RESET && (OUTEN == w_exp_outen);

    // ARMED doubles as the B5 decision phase, so CONV runs with k = 4..0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
            r_k     <= 3'd0;
            r_code  <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            if (w_capture) begin
                r_code[w_cap_idx] <= w_bit;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        case (r_state)
            c_ST_IDLE: begin
                if (SAR_RESET) begin
                    w_state_nxt = c_ST_ARMED;
                end
            end
            c_ST_ARMED: begin
                if (!SAR_RESET) begin
                    if (OUTEN == c_OUTEN_B5) begin
                        w_state_nxt = c_ST_CONV;
                        w_k_nxt     = 3'd4;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            c_ST_CONV: begin
                if (w_conv_ok) begin
                    if (r_k == 3'd0) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_k_nxt = r_k - 3'd1;
                    end
                end else if (SAR_RESET) begin
                    w_state_nxt = c_ST_ARMED;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_capture    = 1'b0;
        w_cap_idx    = 3'd0;
        w_frame_done = 1'b0;
        w_err_evt    = 1'b0;
        case (r_state)
            c_ST_ARMED: begin
                if (!SAR_RESET) begin
                    if (OUTEN == c_OUTEN_B5) begin
                        w_capture = 1'b1;
                        w_cap_idx = 3'd5;
                    end else begin
                        w_err_evt = 1'b1;
                    end
                end
            end
            c_ST_CONV: begin
                if (w_conv_ok) begin
                    w_capture    = 1'b1;
                    w_cap_idx    = r_k;
                    w_frame_done = (r_k == 3'd0);
                end else begin
                    w_err_evt = 1'b1;
                end
            end
            default: begin
                w_capture = 1'b0;
            end
        endcase
    end

`ifdef SAR_CODE_AVG4_EN
    logic [7:0] r_acc;
    logic [1:0] r_avg_cnt;
    logic [7:0] w_sum;

    assign w_sum       = r_acc + {2'b00, w_code_full};
    assign w_push      = w_frame_done && (r_avg_cnt == 2'd3);
    assign w_push_data = w_sum[7:2];

    always_ff @(posedge CLK) begin
        if (RESET || w_err_evt) begin
            r_acc     <= 8'd0;
            r_avg_cnt <= 2'd0;
        end else if (w_frame_done) begin
            if (r_avg_cnt == 2'd3) begin
                r_acc     <= 8'd0;
                r_avg_cnt <= 2'd0;
            end else begin
                r_acc     <= w_sum;
                r_avg_cnt <= r_avg_cnt + 2'd1;
            end
        end
    end
`else
    assign w_push      = w_frame_done;
    assign w_push_data = w_code_full;
`endif

    assign w_pop     = DOUT_VALID && DOUT_READY;
    assign w_full    = (r_count == 2'd2);
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    // Head register is DOUT; a pop on a full buffer promotes the tail.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_head  <= 6'd0;
            r_tail  <= 6'd0;
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head  <= w_push_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= w_push_data;
                    end else if (w_push) begin
                        r_tail  <= w_push_data;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (w_push) begin
                            r_tail <= w_push_data;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
                default: begin
                    r_count <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_seq_err   <= 1'b0;
            r_ovf       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_err_evt) begin
                r_seq_err <= 1'b1;
            end else if (CLR_FLAGS) begin
                r_seq_err <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (CLR_FLAGS) begin
                r_ovf <= 1'b0;
            end
            if (w_push_ok) begin
                r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
            end
        end
    end

    assign DOUT       = r_head;
    assign DOUT_VALID = (r_count != 2'd0);
    assign SEQ_ERR    = r_seq_err;
    assign OVF        = r_ovf;
    assign FRAME_CNT  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sar_code_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_code_capture
// Brief    : Directed-vector bench for sar_code_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_code_capture;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [4:0] OUTEN = 5'b0;
    logic       SAR_RESET = 1'b0;
    logic       VCOMP = 1'b0;
    logic       CLR_FLAGS = 1'b0;
    logic [5:0] DOUT;
    logic       DOUT_VALID;
    logic       DOUT_READY = 1'b0;
    logic       SEQ_ERR;
    logic       OVF;
    logic [7:0] FRAME_CNT;

    int n_vec = 0;
    int n_err = 0;

    sar_code_capture #(.VCOMP_INV(1'b0), .CNT_W(8)) u_dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .OUTEN      (OUTEN),
        .SAR_RESET  (SAR_RESET),
        .VCOMP      (VCOMP),
        .CLR_FLAGS  (CLR_FLAGS),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .SEQ_ERR    (SEQ_ERR),
        .OVF        (OVF),
        .FRAME_CNT  (FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic sr, input logic [4:0] oe, input logic vc);
        @(negedge CLK);
        SAR_RESET = sr;
        OUTEN     = oe;
        VCOMP     = vc;
    endtask

    task automatic idle();
        drive(1'b0, 5'b00000, 1'b0);
    endtask

    task automatic frame(input logic [5:0] code);
        drive(1'b1, 5'b00000, 1'b0);
        for (int k = 5; k >= 1; k--) begin
            drive(1'b0, 5'b00001 << (k - 1), code[k]);
        end
        drive(1'b0, 5'b00000, code[0]);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET     = 1'b1;
        SAR_RESET = 1'b0;
        OUTEN     = 5'b0;
        VCOMP     = 1'b0;
        CLR_FLAGS = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_dout",  DOUT, 6'h00);
        check("rst_valid", DOUT_VALID, 1'b0);
        check("rst_seq",   SEQ_ERR, 1'b0);
        check("rst_ovf",   OVF, 1'b0);
        check("rst_cnt",   FRAME_CNT, 8'd0);

`ifdef SAR_CODE_AVG4_EN
        DOUT_READY = 1'b1;
        frame(6'h10); idle(); check("avg_f1_valid", DOUT_VALID, 1'b0);
        frame(6'h11); idle(); check("avg_f2_valid", DOUT_VALID, 1'b0);
        frame(6'h12); idle(); check("avg_f3_valid", DOUT_VALID, 1'b0);
        frame(6'h13); idle();
        check("avg_dout",  DOUT, 6'h11);
        check("avg_valid", DOUT_VALID, 1'b1);
        check("avg_cnt",   FRAME_CNT, 8'd1);
        check("avg_ovf",   OVF, 1'b0);
        idle();
        check("avg_pop", DOUT_VALID, 1'b0);
`else
        // Clean frame, consumer always ready
        DOUT_READY = 1'b1;
        frame(6'h2D); idle();
        check("t1_dout",  DOUT, 6'h2D);
        check("t1_valid", DOUT_VALID, 1'b1);
        check("t1_cnt",   FRAME_CNT, 8'd1);
        check("t1_seq",   SEQ_ERR, 1'b0);
        idle();
        check("t1_valid_1cyc", DOUT_VALID, 1'b0);

        // Back-to-back frames into a stalled buffer
        do_reset();
        DOUT_READY = 1'b0;
        frame(6'h3F); frame(6'h00); frame(6'h15); idle();
        check("t2_dout",  DOUT, 6'h3F);
        check("t2_valid", DOUT_VALID, 1'b1);
        check("t2_ovf",   OVF, 1'b1);
        check("t2_cnt",   FRAME_CNT, 8'd2);
        idle();
        check("t2_hold",  DOUT, 6'h3F);
        DOUT_READY = 1'b1;
        idle();
        check("t2_second",   DOUT, 6'h00);
        check("t2_second_v", DOUT_VALID, 1'b1);
        idle();
        check("t2_empty", DOUT_VALID, 1'b0);

        // SAR_RESET during B3 restarts the frame
        do_reset();
        drive(1'b1, 5'b00000, 1'b0);
        drive(1'b0, 5'b10000, 1'b1);
        drive(1'b0, 5'b01000, 1'b1);
        drive(1'b1, 5'b00100, 1'b1);
        idle();
        check("t3_seq",   SEQ_ERR, 1'b1);
        check("t3_valid", DOUT_VALID, 1'b0);
        frame(6'h2A); idle();
        check("t3_dout",  DOUT, 6'h2A);
        check("t3_cnt",   FRAME_CNT, 8'd1);

        // Multi-hot OUTEN, flag clear, clear racing a new error
        do_reset();
        drive(1'b1, 5'b00000, 1'b0);
        drive(1'b0, 5'b10000, 1'b0);
        drive(1'b0, 5'b00110, 1'b0);
        idle();
        check("t4_seq", SEQ_ERR, 1'b1);
        check("t4_cnt", FRAME_CNT, 8'd0);
        CLR_FLAGS = 1'b1;
        idle();
        CLR_FLAGS = 1'b0;
        check("t4_clr", SEQ_ERR, 1'b0);
        drive(1'b0, 5'b00100, 1'b0);
        drive(1'b0, 5'b00010, 1'b0);
        drive(1'b0, 5'b00001, 1'b0);
        drive(1'b0, 5'b00000, 1'b0);
        idle();
        check("t4_idle_seq",   SEQ_ERR, 1'b0);
        check("t4_idle_valid", DOUT_VALID, 1'b0);
        drive(1'b1, 5'b00000, 1'b0);
        drive(1'b0, 5'b10000, 1'b0);
        drive(1'b0, 5'b00110, 1'b0);
        CLR_FLAGS = 1'b1;
        idle();
        CLR_FLAGS = 1'b0;
        check("t4_set_wins", SEQ_ERR, 1'b1);

        // Reset mid-B2, then counter wrap
        do_reset();
        drive(1'b1, 5'b00000, 1'b0);
        drive(1'b0, 5'b10000, 1'b1);
        drive(1'b0, 5'b01000, 1'b1);
        drive(1'b0, 5'b00100, 1'b1);
        @(negedge CLK);
        OUTEN = 5'b00010;
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        OUTEN = 5'b00000;
        check("t5_seq",   SEQ_ERR, 1'b0);
        check("t5_valid", DOUT_VALID, 1'b0);
        frame(6'h01); idle();
        check("t5_dout", DOUT, 6'h01);
        check("t5_cnt",  FRAME_CNT, 8'd1);
        idle();
        check("t5_single", DOUT_VALID, 1'b0);
        for (int i = 0; i < 254; i++) begin
            frame(6'(i));
        end
        idle();
        check("t5_cnt_255", FRAME_CNT, 8'd255);
        frame(6'h07); idle();
        check("t5_wrap",  FRAME_CNT, 8'd0);
        check("t5_ovf",   OVF, 1'b0);
        check("t5_last",  DOUT, 6'h07);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
